// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: next-PC source encodings,
// fetch FSM states and the reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_NONE  = 2'b00,
    S_BEQ   = 2'b01,
    S_J_JAL = 2'b10,
    S_JR    = 2'b11
  } pc_src_t;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  // imem_req is held high from request until the cycle imem_ready is high;
  // imem_addr is stable throughout, and imem_rdata is taken only on the edge
  // where imem_req and imem_ready are both high.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC mux. Only the low 26 IR bits (branch offset / jump
// target field) are consumed, so only those are passed in.
module fetch_unit_npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir,
  input  logic [1:0]  s,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (s)
      S_NONE:  next_pc = pc_plus4;
      S_BEQ:   next_pc = zero ? (pc_plus4 + br_offset) : pc_plus4;
      S_J_JAL: next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      S_JR: begin
        next_pc  = word_align(rs_data);
        misalign = (rs_data[1:0] != 2'b00);
      end
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and IR registers, next-PC update and a two-state
// fetch FSM driving the instruction-memory handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_write,
  input  logic          ir_write,
  input  logic [1:0]    s,
  input  logic          zero,
  input  logic [31:0]   rs_data,
  fetch_unit_if.master  imem,
  output logic [31:0]   ir,
  output logic [5:0]    op,
  output logic [5:0]    funct,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic          fetch_busy,
  output logic          addr_err,
  output fetch_state_t  fsm_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  next_pc;
  logic         misalign;
  logic [31:0]  addr_q;
  logic         fetch_start;
  logic         fetch_done;

  fetch_unit_npc u_npc (
    .pc       (pc),
    .ir       (ir[25:0]),
    .s        (s),
    .zero     (zero),
    .rs_data  (rs_data),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  // ir_write during WAIT is a protocol violation and is simply dropped.
  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (ir_write) begin
          fetch_start = 1'b1;
          state_d     = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem.imem_ready) begin
          fetch_done = 1'b1;
          state_d    = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // Fetch address captures the pre-update PC, so a same-edge pc_write is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= 32'h0;
      addr_q   <= RESET_PC;
      addr_err <= 1'b0;
    end else begin
      if (pc_write) pc <= next_pc;
      if (pc_write && misalign) addr_err <= 1'b1;
      if (fetch_start) addr_q <= word_align(pc);
      if (fetch_done) ir <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = (state_q == FS_WAIT);
  assign imem.imem_addr = addr_q;
  assign fetch_busy     = (state_q == FS_WAIT);
  assign fsm_state      = state_q;
  assign pc_plus4       = pc + 32'd4;
  assign op             = ir[31:26];
  assign funct          = ir[5:0];

endmodule
